// File: rtl/ks_adder_pipe.sv
// rtl/ks_adder_pipe.sv - pipelined Kogge-Stone adder/subtractor with stream handshake and flags
module ks_adder_pipe #(
  parameter int WIDTH      = 32,
  parameter int PIPE_EVERY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int NSTG   = (LEVELS + PIPE_EVERY - 1) / PIPE_EVERY;
  localparam int LAST   = NSTG - 1;

  // Global stall: every stage moves together or holds together.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Per-stage sideband: bitwise propagate, carry-in, operand sign bits, valid.
  logic [WIDTH-1:0] st_p  [NSTG];
  logic             st_c0 [NSTG];
  logic             st_am [NSTG];
  logic             st_bm [NSTG];
  logic             st_v  [NSTG];

  logic [WIDTH-1:0] a_r, b_r;
  logic             c0_r, v_r;

  // Input register: B is inverted for subtract ops, carry-in resolved per op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r  <= 1'b0;
      a_r  <= '0;
      b_r  <= '0;
      c0_r <= 1'b0;
    end else if (en) begin
      v_r <= in_valid;
      if (in_valid) begin
        a_r  <= a;
        b_r  <= b ^ {WIDTH{op[1]}};
        c0_r <= (op == 2'b00) ? 1'b0 : (op == 2'b10) ? 1'b1 : cin;
      end
    end
  end

  assign st_p[0]  = a_r ^ b_r;
  assign st_c0[0] = c0_r;
  assign st_am[0] = a_r[WIDTH-1];
  assign st_bm[0] = b_r[WIDTH-1];
  assign st_v[0]  = v_r;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int D = 1 << k;
    logic [WIDTH-1:0] pi, gi, po, go;

    if (k == 0) begin : g_in
      assign pi = a_r ^ b_r;
      assign gi = a_r & b_r;
    end else if ((k % PIPE_EVERY) != 0) begin : g_chain
      assign pi = g_lvl[k-1].po;
      assign gi = g_lvl[k-1].go;
    end else begin : g_bank
      logic [WIDTH-1:0] r_pp, r_gp, r_p;
      logic             r_c0, r_am, r_bm, r_v;

      // Register bank between prefix groups, carrying group P/G and sideband.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pp <= '0;
          r_gp <= '0;
          r_p  <= '0;
          r_c0 <= 1'b0;
          r_am <= 1'b0;
          r_bm <= 1'b0;
          r_v  <= 1'b0;
        end else if (en) begin
          r_pp <= g_lvl[k-1].po;
          r_gp <= g_lvl[k-1].go;
          r_p  <= st_p[k/PIPE_EVERY-1];
          r_c0 <= st_c0[k/PIPE_EVERY-1];
          r_am <= st_am[k/PIPE_EVERY-1];
          r_bm <= st_bm[k/PIPE_EVERY-1];
          r_v  <= st_v[k/PIPE_EVERY-1];
        end
      end

      assign pi                   = r_pp;
      assign gi                   = r_gp;
      assign st_p[k/PIPE_EVERY]   = r_p;
      assign st_c0[k/PIPE_EVERY]  = r_c0;
      assign st_am[k/PIPE_EVERY]  = r_am;
      assign st_bm[k/PIPE_EVERY]  = r_bm;
      assign st_v[k/PIPE_EVERY]   = r_v;
    end

    // Shifted-in zeros/ones make the low D bits pass through unchanged.
    assign go = gi | (pi & {gi[WIDTH-1-D:0], {D{1'b0}}});
    assign po = pi & {pi[WIDTH-1-D:0], {D{1'b1}}};
  end

  logic [WIDTH:0]   c_vec;
  logic [WIDTH-1:0] sum_d;
  assign c_vec = {g_lvl[LEVELS-1].go | (g_lvl[LEVELS-1].po & {WIDTH{st_c0[LAST]}}), st_c0[LAST]};
  assign sum_d = st_p[LAST] ^ c_vec[WIDTH-1:0];

  // Output register: only real beats update the result so it stays clean between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
    end else if (en) begin
      out_valid <= st_v[LAST];
      if (st_v[LAST]) begin
        sum      <= sum_d;
        carry    <= c_vec[WIDTH];
        overflow <= (st_am[LAST] == st_bm[LAST]) && (sum_d[WIDTH-1] != st_am[LAST]);
        zero     <= (sum_d == '0);
        negative <= sum_d[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// tb/tb_ks_adder_pipe.sv - directed self-checking bench for ks_adder_pipe
module tb_ks_adder_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        in_valid, in_ready, out_valid, out_ready, cin;
    logic [1:0]  op;
    logic [31:0] a, b, sum;
    logic        carry, overflow, zero, negative;

    logic        u8_in_valid, u8_in_ready, u8_out_valid, u8_out_ready, u8_cin;
    logic [1:0]  u8_op;
    logic [7:0]  u8_a, u8_b, u8_sum;
    logic        u8_carry, u8_overflow, u8_zero, u8_negative;

    ks_adder_pipe #(.WIDTH(32), .PIPE_EVERY(2)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .overflow(overflow), .zero(zero), .negative(negative)
    );

    ks_adder_pipe #(.WIDTH(8), .PIPE_EVERY(1)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(u8_in_valid), .in_ready(u8_in_ready), .op(u8_op),
        .a(u8_a), .b(u8_b), .cin(u8_cin), .out_valid(u8_out_valid), .out_ready(u8_out_ready),
        .sum(u8_sum), .carry(u8_carry), .overflow(u8_overflow), .zero(u8_zero), .negative(u8_negative)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] ref32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic c);
        logic [31:0] yb;
        logic        c0;
        logic [32:0] s;
        yb = o[1] ? ~y : y;
        c0 = (o == 2'b00) ? 1'b0 : (o == 2'b10) ? 1'b1 : c;
        s  = {1'b0, x} + {1'b0, yb} + {32'b0, c0};
        return {((x[31] == yb[31]) && (s[31] != x[31])), s};
    endfunction

    task automatic run32(input logic [1:0] o, input logic [31:0] xa, input logic [31:0] xb, input logic xc,
                         input logic [31:0] es, input logic ec, input logic ev, input logic ez, input logic en_,
                         input string tag);
        int n;
        @(negedge clk);
        op = o; a = xa; b = xb; cin = xc; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, "_latency"}, n, 3);
        check({tag, "_sum"}, sum, es);
        check({tag, "_carry"}, carry, ec);
        check({tag, "_overflow"}, overflow, ev);
        check({tag, "_zero"}, zero, ez);
        check({tag, "_negative"}, negative, en_);
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                        input logic [7:0] es, input logic ec, input logic ev, input logic ez,
                        input string tag);
        int n;
        @(negedge clk);
        u8_op = o; u8_a = xa; u8_b = xb; u8_cin = xc; u8_in_valid = 1'b1; u8_out_ready = 1'b1;
        @(posedge clk);
        #1 u8_in_valid = 1'b0;
        n = 0;
        while (!u8_out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, "_latency"}, n, 3);
        check({tag, "_sum"}, u8_sum, es);
        check({tag, "_carry"}, u8_carry, ec);
        check({tag, "_overflow"}, u8_overflow, ev);
        check({tag, "_zero"}, u8_zero, ez);
    endtask

    logic [1:0]  s_op  [10];
    logic [31:0] s_a   [10];
    logic [31:0] s_b   [10];
    logic        s_c   [10];
    logic [33:0] s_exp [10];
    int          idx, rcv, seen;
    logic        stall, acc, took, prev_stall;
    logic [31:0] held_sum;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; op = 2'b00; a = '0; b = '0; cin = 1'b0;
        u8_in_valid = 1'b0; u8_out_ready = 1'b1; u8_op = 2'b00; u8_a = '0; u8_b = '0; u8_cin = 1'b0;
        #3;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_sum", sum, 32'h0);
        check("rst_flags", {carry, overflow, zero, negative}, 4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        run32(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, "add_wrap");
        run32(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, "add_ovf");
        run32(2'b10, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1, "sub_borrow");
        run32(2'b11, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 1'b1, "sbc_cin0");
        run32(2'b01, 32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 1'b0, "adc_cin1");
        run32(2'b00, 32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0, "add_ignores_cin");

        run8(2'b10, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0, "w8_sub");
        run8(2'b01, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, "w8_adc");

        for (int i = 0; i < 10; i++) begin
            s_op[i]  = 2'($urandom_range(0, 3));
            s_a[i]   = $urandom;
            s_b[i]   = $urandom;
            s_c[i]   = 1'($urandom_range(0, 1));
            s_exp[i] = ref32(s_op[i], s_a[i], s_b[i], s_c[i]);
        end
        idx = 0; rcv = 0; prev_stall = 1'b0; held_sum = '0;
        for (int cyc = 0; cyc < 40 && rcv < 10; cyc++) begin
            @(negedge clk);
            stall     = (cyc >= 6 && cyc <= 8);
            out_ready = !stall;
            in_valid  = (idx < 10);
            if (idx < 10) begin
                op = s_op[idx]; a = s_a[idx]; b = s_b[idx]; cin = s_c[idx];
            end
            #1;
            if (prev_stall) begin
                check("stall_hold_sum", sum, held_sum);
                check("stall_hold_valid", out_valid, 1'b1);
            end
            check("stream_in_ready", in_ready, !stall);
            acc  = in_valid && in_ready;
            took = out_valid && out_ready;
            if (took) begin
                check("stream_result", {overflow, carry, sum}, s_exp[rcv]);
                rcv++;
            end
            prev_stall = out_valid && !out_ready;
            held_sum   = sum;
            @(posedge clk);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("stream_count", rcv, 10);
        check("stream_accepted", idx, 10);

        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op = 2'b00; a = 32'(i + 1); b = 32'h1; cin = 1'b0; in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        check("pre_reset_valid", out_valid, 1'b1);
        check("pre_reset_sum", sum, 32'h2);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_sum", sum, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_output", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
